// File: rtl/dma_mmio_pkg.sv
// Shared definitions for the DMA MMIO register block: register offsets,
// job states, STATUS bit positions and the offset-to-register decoder.
package dma_mmio_pkg;

  typedef logic [3:0] ofs_t;

  localparam ofs_t GO_OFS      = 4'd0;
  localparam ofs_t RD_ADDR_OFS = 4'd2;
  localparam ofs_t WR_ADDR_OFS = 4'd4;
  localparam ofs_t SIZE_OFS    = 4'd6;
  localparam ofs_t STATUS_OFS  = 4'd8;
  localparam ofs_t CYCLES_OFS  = 4'd10;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_GO,
    SEL_RD_ADDR,
    SEL_WR_ADDR,
    SEL_SIZE,
    SEL_STATUS,
    SEL_CYCLES
  } reg_sel_e;

  // Odd offsets and unlisted even offsets map to SEL_NONE (a miss).
  function automatic reg_sel_e ofs_to_sel(input ofs_t ofs);
    case (ofs)
      GO_OFS:      return SEL_GO;
      RD_ADDR_OFS: return SEL_RD_ADDR;
      WR_ADDR_OFS: return SEL_WR_ADDR;
      SIZE_OFS:    return SEL_SIZE;
      STATUS_OFS:  return SEL_STATUS;
      CYCLES_OFS:  return SEL_CYCLES;
      default:     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_if.sv
// MMIO request/response bundle between the HAL and a register block.
// The user end sinks read/write requests and drives registered read data.
interface mmio_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) ();

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport user (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );

  modport hal (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

endinterface

// File: rtl/dma_mmio_regs_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dma_mmio_regs.sv
// DMA configuration/status register block on the user end of mmio_if:
// holds source/destination/size, issues the go pulse and tracks the job.
module dma_mmio_regs
  import dma_mmio_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR      = 16'h0050,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR        = 16'h005A,
  parameter int                    BYTE_ADDR_WIDTH = 64,
  parameter int                    SIZE_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mmio_if.user                       mmio,
  output logic                       go_o,
  output logic [BYTE_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [BYTE_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [SIZE_WIDTH-1:0]      size_o,
  input  logic                       done_i
);

  localparam logic [ADDR_WIDTH-1:0] SPAN = END_ADDR - START_ADDR;

  state_t                     state_q, state_d;
  logic                       go_q;
  logic [BYTE_ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
  logic [SIZE_WIDTH-1:0]      size_q;
  logic [DATA_WIDTH-1:0]      rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]      cycles;
  logic [DATA_WIDTH-1:0]      rd_value;

  reg_sel_e rd_sel, wr_sel;
  logic     go_accept;
  logic     cfg_wr_ok;
  logic     status_busy, status_done;

  // Unsigned wrap makes addresses below START_ADDR land above SPAN too.
  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] ofs;
    ofs = addr - START_ADDR;
    if (ofs > SPAN) return SEL_NONE;
    return ofs_to_sel(ofs[3:0]);
  endfunction

  assign rd_sel    = decode(mmio.rd_addr);
  assign wr_sel    = decode(mmio.wr_addr);
  assign go_accept = mmio.wr_en && (wr_sel == SEL_GO) && (state_q != BUSY);

  // NOTE: sequential state uses non-blocking <= so every register samples
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no branch can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (go_accept) state_d = BUSY;
      BUSY:       if (done_i)    state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    status_busy = 1'b0;
    status_done = 1'b0;
    case (state_q)
      BUSY:    status_busy = 1'b1;
      DONE:    status_done = 1'b1;
      default: ;
    endcase
    // Config is frozen while a job runs so the DMA sees a stable setup.
    cfg_wr_ok = (state_q != BUSY) && !go_accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q      <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      size_q    <= '0;
    end else begin
      go_q <= go_accept;
      if (mmio.wr_en && cfg_wr_ok) begin
        case (wr_sel)
          SEL_RD_ADDR: rd_addr_q <= mmio.wr_data[BYTE_ADDR_WIDTH-1:0];
          SEL_WR_ADDR: wr_addr_q <= mmio.wr_data[BYTE_ADDR_WIDTH-1:0];
          SEL_SIZE:    size_q    <= mmio.wr_data[SIZE_WIDTH-1:0];
          default:     ;
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH (DATA_WIDTH)
  ) u_cycles (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (go_accept),
    .inc_i   (status_busy),
    .count_o (cycles)
  );

  always_comb begin
    rd_value = '0;
    case (rd_sel)
      SEL_RD_ADDR: rd_value = DATA_WIDTH'(rd_addr_q);
      SEL_WR_ADDR: rd_value = DATA_WIDTH'(wr_addr_q);
      SEL_SIZE:    rd_value = DATA_WIDTH'(size_q);
      SEL_STATUS: begin
        rd_value[STATUS_DONE_BIT] = status_done;
        rd_value[STATUS_BUSY_BIT] = status_busy;
      end
      SEL_CYCLES:  rd_value = cycles;
      default:     rd_value = '0;
    endcase
    rd_data_d = mmio.rd_en ? rd_value : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign mmio.rd_data = rd_data_q;
  assign go_o         = go_q;
  assign rd_addr_o    = rd_addr_q;
  assign wr_addr_o    = wr_addr_q;
  assign size_o       = size_q;

endmodule

// File: tb/tb_dma_mmio_regs.sv
// Directed bench for dma_mmio_regs: a vector table for single-cycle register
// traffic, then hand sequences for the job lifecycle, lock and async reset.
module tb_dma_mmio_regs;
  import dma_mmio_pkg::*;

  localparam logic [15:0] A_GO  = 16'h0050;
  localparam logic [15:0] A_RDA = 16'h0052;
  localparam logic [15:0] A_WRA = 16'h0054;
  localparam logic [15:0] A_SZ  = 16'h0056;
  localparam logic [15:0] A_ST  = 16'h0058;
  localparam logic [15:0] A_CY  = 16'h005A;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go_o;
  logic [63:0] rd_addr_o, wr_addr_o;
  logic [31:0] size_o;
  logic        done_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_if #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) mmio ();

  dma_mmio_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mmio      (mmio),
    .go_o      (go_o),
    .rd_addr_o (rd_addr_o),
    .wr_addr_o (wr_addr_o),
    .size_o    (size_o),
    .done_i    (done_i)
  );

  typedef struct {
    logic        wr;
    logic [15:0] waddr;
    logic [63:0] wdata;
    logic        rd;
    logic [15:0] raddr;
    logic [63:0] exp_rd;
    logic [63:0] exp_src;
    logic [63:0] exp_dst;
    logic [31:0] exp_size;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [15:0] wa, input logic [63:0] wd,
                              input logic rd, input logic [15:0] ra, input logic [63:0] er,
                              input logic [63:0] es, input logic [63:0] ed, input logic [31:0] ez);
    vec_t v;
    v.wr = wr; v.waddr = wa; v.wdata = wd;
    v.rd = rd; v.raddr = ra; v.exp_rd = er;
    v.exp_src = es; v.exp_dst = ed; v.exp_size = ez;
    return v;
  endfunction

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [15:0] a, input logic [63:0] d);
    mmio.wr_en   = 1'b1;
    mmio.wr_addr = a;
    mmio.wr_data = d;
    cycle();
    mmio.wr_en = 1'b0;
  endtask

  task automatic mmio_read(input logic [15:0] a, output logic [63:0] d);
    mmio.rd_en   = 1'b1;
    mmio.rd_addr = a;
    cycle();
    mmio.rd_en = 1'b0;
    d = mmio.rd_data;
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    cycle();
    done_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " go_o"},    64'(go_o), 64'h0);
    check({tag, " rd_addr"}, rd_addr_o, 64'h0);
    check({tag, " wr_addr"}, wr_addr_o, 64'h0);
    check({tag, " size"},    64'(size_o), 64'h0);
    check({tag, " rd_data"}, mmio.rd_data, 64'h0);
  endtask

  initial begin
    logic [63:0] r;

    //                wr    waddr  wdata                   rd    raddr  exp_rd        src           dst      size
    vecs[0]  = mk(1'b0, A_GO,  64'h0,                  1'b1, A_GO,  64'h0,        64'h0,        64'h0,    32'h0);
    vecs[1]  = mk(1'b0, A_GO,  64'h0,                  1'b1, A_RDA, 64'h0,        64'h0,        64'h0,    32'h0);
    vecs[2]  = mk(1'b0, A_GO,  64'h0,                  1'b1, A_WRA, 64'h0,        64'h0,        64'h0,    32'h0);
    vecs[3]  = mk(1'b0, A_GO,  64'h0,                  1'b1, A_SZ,  64'h0,        64'h0,        64'h0,    32'h0);
    vecs[4]  = mk(1'b0, A_GO,  64'h0,                  1'b1, A_ST,  64'h0,        64'h0,        64'h0,    32'h0);
    vecs[5]  = mk(1'b0, A_GO,  64'h0,                  1'b1, A_CY,  64'h0,        64'h0,        64'h0,    32'h0);
    vecs[6]  = mk(1'b1, A_RDA, 64'h1000,               1'b0, A_GO,  64'h0,        64'h1000,     64'h0,    32'h0);
    vecs[7]  = mk(1'b1, A_WRA, 64'h2000,               1'b1, A_RDA, 64'h1000,     64'h1000,     64'h2000, 32'h0);
    vecs[8]  = mk(1'b1, A_SZ,  64'h1_0000_0010,        1'b1, A_WRA, 64'h2000,     64'h1000,     64'h2000, 32'h10);
    vecs[9]  = mk(1'b0, A_GO,  64'h0,                  1'b1, A_SZ,  64'h10,       64'h1000,     64'h2000, 32'h10);
    vecs[10] = mk(1'b1, A_RDA, 64'hDEAD_BEEF,          1'b1, A_RDA, 64'h1000,     64'hDEAD_BEEF, 64'h2000, 32'h10);
    vecs[11] = mk(1'b1, A_RDA, 64'h1000,               1'b1, A_RDA, 64'hDEAD_BEEF, 64'h1000,    64'h2000, 32'h10);
    vecs[12] = mk(1'b1, 16'h004F, ONES,                1'b1, 16'h004F, 64'h0,     64'h1000,     64'h2000, 32'h10);
    vecs[13] = mk(1'b1, 16'h0051, ONES,                1'b1, 16'h0051, 64'h0,     64'h1000,     64'h2000, 32'h10);
    vecs[14] = mk(1'b1, 16'h005B, ONES,                1'b1, 16'h005B, 64'h0,     64'h1000,     64'h2000, 32'h10);
    vecs[15] = mk(1'b1, A_ST,  ONES,                   1'b1, A_GO,  64'h0,        64'h1000,     64'h2000, 32'h10);
    vecs[16] = mk(1'b1, A_CY,  ONES,                   1'b1, A_ST,  64'h0,        64'h1000,     64'h2000, 32'h10);
    vecs[17] = mk(1'b1, 16'h0053, ONES,                1'b1, A_CY,  64'h0,        64'h1000,     64'h2000, 32'h10);
    vecs[18] = mk(1'b0, A_GO,  64'h0,                  1'b1, 16'h0053, 64'h0,     64'h1000,     64'h2000, 32'h10);

    rst_n        = 1'b0;
    done_i       = 1'b0;
    mmio.rd_en   = 1'b0;
    mmio.wr_en   = 1'b0;
    mmio.rd_addr = '0;
    mmio.wr_addr = '0;
    mmio.wr_data = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single-cycle register traffic, all in IDLE.
    for (int i = 0; i < NV; i++) begin
      mmio.wr_en   = vecs[i].wr;
      mmio.wr_addr = vecs[i].waddr;
      mmio.wr_data = vecs[i].wdata;
      mmio.rd_en   = vecs[i].rd;
      mmio.rd_addr = vecs[i].raddr;
      cycle();
      mmio.wr_en = 1'b0;
      mmio.rd_en = 1'b0;
      if (vecs[i].rd) check($sformatf("vec%0d rd_data", i), mmio.rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d rd_addr_o", i), rd_addr_o, vecs[i].exp_src);
      check($sformatf("vec%0d wr_addr_o", i), wr_addr_o, vecs[i].exp_dst);
      check($sformatf("vec%0d size_o", i), 64'(size_o), 64'(vecs[i].exp_size));
      check($sformatf("vec%0d go_o", i), 64'(go_o), 64'h0);
    end

    // done_i while IDLE must not move the state.
    pulse_done();
    mmio_read(A_ST, r);
    check("idle done ignored", r, 64'h0);

    // First job: GO at edge E0, done sampled at E21 -> CYCLES 21.
    mmio_write(A_GO, 64'h0);
    check("go pulse", 64'(go_o), 64'h1);
    mmio_read(A_ST, r);
    check("status busy", r, 64'h2);
    check("go one cycle", 64'(go_o), 64'h0);
    repeat (19) cycle();
    pulse_done();
    mmio_read(A_CY, r);
    check("cycles job1", r, 64'd21);
    mmio_read(A_ST, r);
    check("status done", r, 64'h1);

    // Second job: config writes and a second GO are locked out while BUSY.
    mmio_write(A_GO, ONES);
    check("restart pulse", 64'(go_o), 64'h1);
    mmio_write(A_SZ, 64'h5);
    mmio_write(A_RDA, 64'h7777);
    mmio_write(A_GO, 64'h0);
    check("busy go ignored", 64'(go_o), 64'h0);
    check("busy size locked", 64'(size_o), 64'h10);
    check("busy rd_addr locked", rd_addr_o, 64'h1000);
    mmio_read(A_SZ, r);
    check("busy size readback", r, 64'h10);
    pulse_done();
    mmio_read(A_CY, r);
    check("cycles job2", r, 64'd5);
    mmio_read(A_ST, r);
    check("status done job2", r, 64'h1);

    // Third job: CYCLES reads 0 right after the restart, then async reset mid-BUSY.
    mmio_write(A_GO, 64'h0);
    mmio_read(A_CY, r);
    check("cycles restart", r, 64'h0);
    mmio_read(A_ST, r);
    check("status busy job3", r, 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid-busy reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    mmio_read(A_ST, r);
    check("status after reset", r, 64'h0);

    // Reset landing while go_o is high forces it low at once.
    mmio_write(A_GO, 64'h0);
    check("go before reset", 64'(go_o), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("go forced low", 64'(go_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    mmio_read(A_ST, r);
    check("status idle again", r, 64'h0);
    mmio_read(A_CY, r);
    check("cycles after reset", r, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
